// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: RV32I size codes,
// FSM state encoding and the request legality check.
package dmem_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Misaligned halves/words, and size codes that do not exist for the access kind.
  function automatic logic req_err(input logic we, input logic [2:0] f3, input logic [1:0] lane);
    logic e;
    e = 1'b0;
    if ((f3 == F3_H || f3 == F3_HU) && lane[0]) e = 1'b1;
    if (f3 == F3_W && lane != 2'b00) e = 1'b1;
    if (we && !(f3 == F3_B || f3 == F3_H || f3 == F3_W)) e = 1'b1;
    if (!we && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)) e = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Core request/response handshake plus word-indexed memory port of the LSU.
// Handshake: a request transfers on a rising edge where req_valid_in and
// req_ready_out are both high; rsp_valid_out is a one-cycle completion pulse.
interface dmem_lsu_if #(parameter int ADDR_W = 32);

  logic                 req_valid_in;
  logic                 req_ready_out;
  logic                 req_we_in;
  logic [2:0]           req_funct3_in;
  logic [ADDR_W-1:0]    req_addr_in;
  logic [31:0]          req_wdata_in;
  logic                 rsp_valid_out;
  logic [31:0]          rsp_rdata_out;
  logic                 rsp_err_out;
  logic                 mem_wr_en_out;
  logic [31:0]          mem_wr_addr_out;
  logic [31:0]          mem_wr_data_out;
  logic [31:0]          mem_rd_addr_out;
  logic [31:0]          mem_rd_data_in;
  dmem_lsu_pkg::state_t dbg_state_out;

  modport slave (
    input  req_valid_in, req_we_in, req_funct3_in, req_addr_in, req_wdata_in, mem_rd_data_in,
    output req_ready_out, rsp_valid_out, rsp_rdata_out, rsp_err_out,
           mem_wr_en_out, mem_wr_addr_out, mem_wr_data_out, mem_rd_addr_out, dbg_state_out
  );

  modport master (
    output req_valid_in, req_we_in, req_funct3_in, req_addr_in, req_wdata_in, mem_rd_data_in,
    input  req_ready_out, rsp_valid_out, rsp_rdata_out, rsp_err_out,
           mem_wr_en_out, mem_wr_addr_out, mem_wr_data_out, mem_rd_addr_out, dbg_state_out
  );

endinterface

// File: rtl/dmem_lsu_align.sv
// Combinational lane logic: extract/extend a load from a memory word, and
// merge store data into the addressed byte/half lane of a captured word.
module dmem_lsu_align
  import dmem_lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] rd_word_i,
  input  logic [31:0] base_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_word_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rd_word_i[7:0];
    case (lane_i)
      2'd1:    byte_sel = rd_word_i[15:8];
      2'd2:    byte_sel = rd_word_i[23:16];
      2'd3:    byte_sel = rd_word_i[31:24];
      default: byte_sel = rd_word_i[7:0];
    endcase
    half_sel = lane_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];

    load_data_o = 32'h0;
    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data_o = {24'h0, byte_sel};
      F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data_o = {16'h0, half_sel};
      F3_W:    load_data_o = rd_word_i;
      default: load_data_o = 32'h0;
    endcase
  end

  always_comb begin
    merged_word_o = wdata_i;
    case (funct3_i)
      F3_B: begin
        case (lane_i)
          2'd0:    merged_word_o = {base_word_i[31:8], wdata_i[7:0]};
          2'd1:    merged_word_o = {base_word_i[31:16], wdata_i[7:0], base_word_i[7:0]};
          2'd2:    merged_word_o = {base_word_i[31:24], wdata_i[7:0], base_word_i[15:0]};
          default: merged_word_o = {wdata_i[7:0], base_word_i[23:0]};
        endcase
      end
      F3_H:    merged_word_o = lane_i[1] ? {wdata_i[15:0], base_word_i[15:0]}
                                         : {base_word_i[31:16], wdata_i[15:0]};
      default: merged_word_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Data-memory load/store unit: one request at a time, read-modify-write for
// sub-word stores, registered response with error flag.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic      clkin,
  input  logic      rst_in,
  dmem_lsu_if.slave bus
);

  state_t            state_q, state_d;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              ready;
  logic              accept;
  logic              err_c;
  logic [31:0]       load_data;
  logic [31:0]       merged_word;
  logic [31:0]       word_addr;

  assign ready  = (state_q == IDLE) && !rst_in;
  assign accept = bus.req_valid_in && ready;
  assign err_c  = req_err(bus.req_we_in, bus.req_funct3_in, bus.req_addr_in[1:0]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (err_c)                                        state_d = RESP;
          else if (!bus.req_we_in || bus.req_funct3_in != F3_W) state_d = READ;
          else                                              state_d = WRITE;
        end
      end
      READ:    state_d = we_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkin or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      word_q   <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q     <= bus.req_we_in;
        funct3_q <= bus.req_funct3_in;
        addr_q   <= bus.req_addr_in;
        wdata_q  <= bus.req_wdata_in;
        err_q    <= err_c;
        rdata_q  <= 32'h0;
      end
      // Keep the read word for a sub-word merge; loads latch their result here.
      if (state_q == READ) begin
        word_q <= bus.mem_rd_data_in;
        if (!we_q) rdata_q <= load_data;
      end
    end
  end

  dmem_lsu_align u_align (
    .funct3_i      (funct3_q),
    .lane_i        (addr_q[1:0]),
    .rd_word_i     (bus.mem_rd_data_in),
    .base_word_i   (word_q),
    .wdata_i       (wdata_q),
    .load_data_o   (load_data),
    .merged_word_o (merged_word)
  );

  assign word_addr           = 32'(addr_q[ADDR_W-1:2]);
  assign bus.req_ready_out   = ready;
  assign bus.mem_rd_addr_out = word_addr;
  assign bus.mem_wr_addr_out = word_addr;
  assign bus.mem_wr_en_out   = (state_q == WRITE);
  assign bus.mem_wr_data_out = merged_word;
  assign bus.rsp_valid_out   = (state_q == RESP);
  assign bus.rsp_rdata_out   = rdata_q;
  assign bus.rsp_err_out     = err_q;
  assign bus.dbg_state_out   = state_q;

endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning byte-address width of core requests.
REQ-002 SHALL have port clkin  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_in  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid_in  input  1  core request present.
REQ-005 SHALL have port req_ready_out  output  1  unit can accept a request.
REQ-006 SHALL have port req_we_in  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3_in  input  3  RV32I size/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 SHALL have port req_addr_in  input  ADDR_W  byte address.
REQ-009 SHALL have port req_wdata_in  input  32  store data, right-aligned.
REQ-010 SHALL have port rsp_valid_out  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata_out  output  32  load result, extended; 0 for stores and errors.
REQ-012 SHALL have port rsp_err_out  output  1  misaligned or illegal funct3; valid with rsp_valid_out.
REQ-013 SHALL have ports mem_wr_en_out output 1, mem_wr_addr_out output 32, mem_wr_data_out output 32: word-indexed memory write port.
REQ-014 SHALL have ports mem_rd_addr_out output 32, mem_rd_data_in input 32: word-indexed memory read port, combinational read.

Function
REQ-015 SHALL use states IDLE, READ, WRITE, RESP; req_ready_out = 1 only in IDLE with rst_in low.
REQ-016 SHALL accept a request on a rising edge with req_valid_in & req_ready_out, registering we, funct3, addr, wdata.
REQ-017 SHALL drive mem_rd_addr_out and mem_wr_addr_out = {2'b0, addr[31:2]} from the registered address.
REQ-018 SHALL flag error when funct3 is H/HU with addr[0]=1, W with addr[1:0]!=0, store funct3 not in {000,001,010}, or load funct3 in {011,110,111}.
REQ-019 Transitions: IDLE->RESP on error; IDLE->READ on any load or SB/SH; IDLE->WRITE on SW; READ->RESP for load; READ->WRITE for SB/SH; WRITE->RESP; RESP->IDLE unconditionally.
REQ-020 In READ SHALL capture mem_rd_data_in into an internal word register on the exiting edge.
REQ-021 Loads SHALL extract lane addr[1:0] (byte) or addr[1] (half), sign-extend for B/H, zero-extend for BU/HU.
REQ-022 In WRITE mem_wr_en_out SHALL be 1 for exactly one cycle; SW writes wdata; SB/SH write captured word with only addressed lane(s) replaced by wdata[7:0]/wdata[15:0].
REQ-023 mem_wr_en_out SHALL be 0 in every state except WRITE; errored requests SHALL never write.
REQ-024 rsp_valid_out SHALL be 1 only in RESP; rsp_rdata_out/rsp_err_out SHALL be registered and stable during RESP.
REQ-025 Latency from accepting edge to rsp_valid_out high: error 1 edge; SW 2; load 2; SB/SH 3.
REQ-026 With req_valid_in held high, the next request SHALL be accepted on the edge leaving IDLE, i.e. one cycle after RESP.
REQ-027 Request inputs SHALL be ignored outside IDLE; their changes SHALL not affect an in-flight operation.

Reset
REQ-028 rst_in high SHALL immediately force state IDLE, req_ready_out 0, rsp_valid_out 0, rsp_err_out 0, rsp_rdata_out 0, mem_wr_en_out 0, mem addresses/data 0.
REQ-029 Reset mid-operation SHALL abort the request with no write and no response; first acceptance possible on first edge after rst_in falls.

Structure
REQ-030 SHALL place funct3 codes and state encodings in shared package dmem_lsu_pkg.
REQ-031 SHALL implement lane extract/extend and lane merge in combinational sub-module dmem_lsu_align.

Verification
REQ-032 Word 4 = 0x87654321: LB 0x13 -> rdata 0xFFFFFF87; LBU 0x13 -> 0x00000087; rsp 2 edges after accept.
REQ-033 SH 0xBEEF at 0x12 over 0x87654321 -> single write word 4 = 0xBEEF4321; rsp 3 edges after accept, err 0.
REQ-034 SW 0x11, and load funct3 011 at 0x10 -> rsp_err 1 after 1 edge, rdata 0, mem_wr_en never high.
REQ-035 Word 4 = 0x00008001: LH 0x10 -> 0xFFFF8001; LHU 0x10 -> 0x00008001; LW 0x10 -> 0x00008001.
REQ-036 SB 0xAA at 0x10, rst_in pulsed during READ -> no mem_wr_en, memory unchanged, req_ready 1 first cycle after release.
REQ-037 Two SW held back-to-back (0x10, 0x14) -> two single-cycle writes, second accept one cycle after first rsp.
